// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of committed word stores between MEM and the data cache,
// drained oldest-first, with youngest-match forwarding to loads.
module store_buffer #(
   parameter int ENTRY_COUNT = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enq_valid,
   input  logic [31:0]                   enq_addr,
   input  logic [31:0]                   enq_data,
   output logic                          enq_ready,
   input  logic                          deq_req,
   output logic [31:0]                   deq_addr,
   output logic [31:0]                   deq_data,
   output logic                          deq_valid,
   input  logic [31:0]                   load_addr,
   output logic [31:0]                   sb_load_data,
   output logic                          sb_load_hit,
   output logic [$clog2(ENTRY_COUNT):0]  count_out,
   output logic                          full,
   input  logic                          flush,
   input  logic [2:0]                    excpt_in
);
   localparam int AW = $clog2(ENTRY_COUNT);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   entry_t          store_buf [ENTRY_COUNT];
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [CW-1:0]   r_count;
   logic            w_enq;
   logic            w_deq;
   logic            w_full;

   assign w_full    = r_count == CW'(ENTRY_COUNT);
   assign full      = w_full;
   assign enq_ready = ~w_full;
   assign deq_valid = r_count != '0;
   assign count_out = r_count;
   assign deq_addr  = deq_valid ? store_buf[r_head].addr : '0;
   assign deq_data  = deq_valid ? store_buf[r_head].data : '0;
   assign w_enq     = enq_valid && enq_ready && excpt_in == 3'b000 && !flush;
   assign w_deq     = deq_req && deq_valid && !flush;

   // Walk oldest to youngest so the last match wins; byte offset bits are masked off.
   always_comb begin
      sb_load_hit  = 1'b0;
      sb_load_data = '0;
      for (int k = 0; k < ENTRY_COUNT; k++) begin
         if (store_buf[r_head + AW'(k)].valid &&
             ((store_buf[r_head + AW'(k)].addr ^ load_addr) & 32'hFFFF_FFFC) == 32'h0) begin
            sb_load_hit  = 1'b1;
            sb_load_data = store_buf[r_head + AW'(k)].data;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRY_COUNT; i++) store_buf[i] <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         for (int i = 0; i < ENTRY_COUNT; i++) store_buf[i].valid <= 1'b0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            store_buf[r_tail] <= '{valid: 1'b1, addr: enq_addr, data: enq_data};
            r_tail            <= r_tail + 1'b1;
         end
         if (w_deq) begin
            store_buf[r_head].valid <= 1'b0;
            r_head                  <= r_head + 1'b1;
         end
         r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven checks of enqueue/dequeue/forwarding plus hand-written
// wrap-around, same-cycle visibility and asynchronous reset sequences.
module tb_store_buffer;
   logic        clock;
   logic        reset;
   logic        enq_valid;
   logic [31:0] enq_addr;
   logic [31:0] enq_data;
   logic        enq_ready;
   logic        deq_req;
   logic [31:0] deq_addr;
   logic [31:0] deq_data;
   logic        deq_valid;
   logic [31:0] load_addr;
   logic [31:0] sb_load_data;
   logic        sb_load_hit;
   logic [2:0]  count_out;
   logic        full;
   logic        flush;
   logic [2:0]  excpt_in;

   int n_chk  = 0;
   int n_fail = 0;

   store_buffer #(.ENTRY_COUNT(4)) dut (
      .clock(clock), .reset(reset),
      .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_ready(enq_ready),
      .deq_req(deq_req), .deq_addr(deq_addr), .deq_data(deq_data), .deq_valid(deq_valid),
      .load_addr(load_addr), .sb_load_data(sb_load_data), .sb_load_hit(sb_load_hit),
      .count_out(count_out), .full(full), .flush(flush), .excpt_in(excpt_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        ev;
      logic [31:0] ea;
      logic [31:0] ed;
      logic        dq;
      logic [31:0] la;
      logic        fl;
      logic [2:0]  ex;
      logic [2:0]  cnt;
      logic        dv;
      logic [31:0] da;
      logic [31:0] dd;
      logic        fu;
      logic        hit;
      logic [31:0] ld;
   } vec_t;

   localparam int NV = 21;
   vec_t v [NV];

   function automatic vec_t mk(input int ev, input int ea, input int ed, input int dq,
                               input int la, input int fl, input int ex, input int cnt,
                               input int dv, input int da, input int dd, input int fu,
                               input int hit, input int ld);
      vec_t r;
      r.ev = ev[0];   r.ea = ea;        r.ed = ed;      r.dq = dq[0];
      r.la = la;      r.fl = fl[0];     r.ex = ex[2:0]; r.cnt = cnt[2:0];
      r.dv = dv[0];   r.da = da;        r.dd = dd;      r.fu = fu[0];
      r.hit = hit[0]; r.ld = ld;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                        input logic dq, input logic [31:0] la, input logic fl,
                        input logic [2:0] ex);
      enq_valid = ev; enq_addr = ea; enq_data = ed; deq_req = dq;
      load_addr = la; flush = fl; excpt_in = ex;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000);
      // cols: ev ea ed dq la fl ex | cnt dv da dd full hit ld
      v[0]  = mk(1, 'h100, 'hAAAA0001, 0, 'h100, 0, 0,  1, 1, 'h100, 'hAAAA0001, 0, 1, 'hAAAA0001);
      v[1]  = mk(1, 'h104, 'hBBBB0002, 0, 'h104, 0, 0,  2, 1, 'h100, 'hAAAA0001, 0, 1, 'hBBBB0002);
      v[2]  = mk(0, 0, 0, 1, 'h100, 0, 0,               1, 1, 'h104, 'hBBBB0002, 0, 0, 0);
      v[3]  = mk(0, 0, 0, 1, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0);
      v[4]  = mk(0, 0, 0, 1, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0);
      v[5]  = mk(1, 'h10, 1, 0, 'h30, 0, 0,             1, 1, 'h10, 1, 0, 0, 0);
      v[6]  = mk(1, 'h20, 2, 0, 'h30, 0, 0,             2, 1, 'h10, 1, 0, 0, 0);
      v[7]  = mk(1, 'h30, 3, 0, 'h30, 0, 0,             3, 1, 'h10, 1, 0, 1, 3);
      v[8]  = mk(1, 'h40, 4, 0, 'h30, 0, 0,             4, 1, 'h10, 1, 1, 1, 3);
      v[9]  = mk(1, 'h50, 5, 0, 'h50, 0, 0,             4, 1, 'h10, 1, 1, 0, 0);
      v[10] = mk(1, 'h50, 5, 1, 'h50, 0, 0,             3, 1, 'h20, 2, 0, 0, 0);
      v[11] = mk(1, 'h50, 5, 0, 'h50, 0, 0,             4, 1, 'h20, 2, 1, 1, 5);
      v[12] = mk(1, 'h60, 6, 1, 'h20, 1, 0,             0, 0, 0, 0, 0, 0, 0);
      v[13] = mk(1, 'h200, 'h11, 0, 'h200, 0, 0,        1, 1, 'h200, 'h11, 0, 1, 'h11);
      v[14] = mk(1, 'h200, 'h22, 0, 'h200, 0, 0,        2, 1, 'h200, 'h11, 0, 1, 'h22);
      v[15] = mk(0, 0, 0, 0, 'h202, 0, 0,               2, 1, 'h200, 'h11, 0, 1, 'h22);
      v[16] = mk(0, 0, 0, 0, 'h204, 0, 0,               2, 1, 'h200, 'h11, 0, 0, 0);
      v[17] = mk(1, 'h300, 'h33, 0, 'h300, 0, 1,        2, 1, 'h200, 'h11, 0, 0, 0);
      v[18] = mk(1, 'h300, 'h33, 0, 'h300, 0, 4,        2, 1, 'h200, 'h11, 0, 0, 0);
      v[19] = mk(1, 'h204, 'h44, 0, 'h204, 0, 0,        3, 1, 'h200, 'h11, 0, 1, 'h44);
      v[20] = mk(0, 0, 0, 0, 'h200, 1, 0,               0, 0, 0, 0, 0, 0, 0);

      #12;
      chk("rst count", 32'(count_out), 32'd0);
      chk("rst deq_valid", 32'(deq_valid), 32'd0);
      chk("rst enq_ready", 32'(enq_ready), 32'd1);
      chk("rst full", 32'(full), 32'd0);
      chk("rst hit", 32'(sb_load_hit), 32'd0);
      chk("rst ldata", sb_load_data, 32'd0);
      chk("rst deq_addr", deq_addr, 32'd0);
      reset = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < NV; i++) begin
         drive(v[i].ev, v[i].ea, v[i].ed, v[i].dq, v[i].la, v[i].fl, v[i].ex);
         @(posedge clock); #1;
         chk($sformatf("v%0d count", i), 32'(count_out), 32'(v[i].cnt));
         chk($sformatf("v%0d deq_valid", i), 32'(deq_valid), 32'(v[i].dv));
         chk($sformatf("v%0d deq_addr", i), deq_addr, v[i].da);
         chk($sformatf("v%0d deq_data", i), deq_data, v[i].dd);
         chk($sformatf("v%0d full", i), 32'(full), 32'(v[i].fu));
         chk($sformatf("v%0d enq_ready", i), 32'(enq_ready), 32'(!v[i].fu));
         chk($sformatf("v%0d hit", i), 32'(sb_load_hit), 32'(v[i].hit));
         chk($sformatf("v%0d ldata", i), sb_load_data, v[i].ld);
      end

      // Three entries resident, then six enq+deq pairs so both pointers wrap.
      for (int i = 0; i < 9; i++) begin
         int h;
         drive(1'b1, 32'h1000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), i >= 3, 32'h0, 1'b0, 3'b000);
         @(posedge clock); #1;
         h = (i < 3) ? 0 : i - 2;
         chk($sformatf("wrap%0d count", i), 32'(count_out), (i < 3) ? 32'(i + 1) : 32'd3);
         chk($sformatf("wrap%0d deq_addr", i), deq_addr, 32'h1000 + 32'(4 * h));
         chk($sformatf("wrap%0d deq_data", i), deq_data, 32'hC0DE0000 + 32'(h));
      end
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 3'b000);
         #1;
         chk($sformatf("drain%0d deq_addr", j), deq_addr, 32'h1000 + 32'(4 * (6 + j)));
         chk($sformatf("drain%0d deq_data", j), deq_data, 32'hC0DE0000 + 32'(6 + j));
         @(posedge clock); #1;
         chk($sformatf("drain%0d count", j), 32'(count_out), 32'(2 - j));
      end

      // An entry being enqueued is not forwarded until after its edge.
      drive(1'b1, 32'h400, 32'h4444, 1'b0, 32'h400, 1'b0, 3'b000);
      #1;
      chk("same-cycle hit", 32'(sb_load_hit), 32'd0);
      chk("same-cycle ldata", sb_load_data, 32'd0);
      @(posedge clock); #1;
      chk("next-cycle hit", 32'(sb_load_hit), 32'd1);
      chk("next-cycle ldata", sb_load_data, 32'h4444);

      drive(1'b1, 32'h500, 32'h5555, 1'b0, 32'h500, 1'b0, 3'b000);
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      chk("async count", 32'(count_out), 32'd0);
      chk("async deq_valid", 32'(deq_valid), 32'd0);
      chk("async deq_addr", deq_addr, 32'd0);
      chk("async hit", 32'(sb_load_hit), 32'd0);
      chk("async ldata", sb_load_data, 32'd0);
      chk("async enq_ready", 32'(enq_ready), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h500, 1'b0, 3'b000);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("post-reset count", 32'(count_out), 32'd0);
      chk("post-reset hit", 32'(sb_load_hit), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
